regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port between three writeback sources: ALU, load unit (MEM) and multiply/divide unit (MD).
- Each source offers a valid/ready write request. The arbiter grants at most one per cycle and drives the registered write port (Write1/WriteReg1/WriteData1) straight into the register file.
- Sits between the execute/memory stages and the register file. It holds no architectural state except the arbitration pointer and the output register.

---
 rtl/regfile_wb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between the ALU, MEM and MD sources.
// Macro WBARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed priority MEM > MD > ALU.
module regfile_wb_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int DROP_R0 = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Hold,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluReg,
  input  logic [DATA_W-1:0] AluData,
  output logic              AluReady,
  input  logic              MemValid,
  input  logic [ADDR_W-1:0] MemReg,
  input  logic [DATA_W-1:0] MemData,
  output logic              MemReady,
  input  logic              MdValid,
  input  logic [ADDR_W-1:0] MdReg,
  input  logic [DATA_W-1:0] MdData,
  output logic              MdReady,
  output logic              Write1,
  output logic [ADDR_W-1:0] WriteReg1,
  output logic [DATA_W-1:0] WriteData1,
  output logic              Conflict
);

  // Source vectors are ordered bit0 = ALU, bit1 = MEM, bit2 = MD.
  logic [2:0]        w_valid;
  logic [2:0]        w_gnt;
  logic              w_any_gnt;
  logic              w_multi;
  logic              w_drop;
  logic [ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0] w_sel_data;

  logic              r_write;
  logic [ADDR_W-1:0] r_reg;
  logic [DATA_W-1:0] r_data;
  logic              r_conflict;

  assign w_valid = {MdValid, MemValid, AluValid};
  assign w_multi = (w_valid[0] & w_valid[1]) | (w_valid[0] & w_valid[2]) | (w_valid[1] & w_valid[2]);

`ifdef WBARB_ROUND_ROBIN_EN
  typedef enum logic [1:0] {
    PTR_ALU = 2'd0,
    PTR_MEM = 2'd1,
    PTR_MD  = 2'd2
  } ptr_e;

  ptr_e r_ptr;
  ptr_e w_ptr_nxt;

  // Arbitration pointer register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ptr <= PTR_ALU;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Round-robin search from the pointer; the pointer moves past the winner.
  always_comb begin
    w_gnt     = 3'b000;
    w_ptr_nxt = r_ptr;
    if (RESET || Hold) begin
      w_gnt = 3'b000;
    end else begin
      case (r_ptr)
        PTR_MEM: begin
          if      (w_valid[1]) w_gnt = 3'b010;
          else if (w_valid[2]) w_gnt = 3'b100;
          else if (w_valid[0]) w_gnt = 3'b001;
          else                 w_gnt = 3'b000;
        end
        PTR_MD: begin
          if      (w_valid[2]) w_gnt = 3'b100;
          else if (w_valid[0]) w_gnt = 3'b001;
          else if (w_valid[1]) w_gnt = 3'b010;
          else                 w_gnt = 3'b000;
        end
        default: begin
          if      (w_valid[0]) w_gnt = 3'b001;
          else if (w_valid[1]) w_gnt = 3'b010;
          else if (w_valid[2]) w_gnt = 3'b100;
          else                 w_gnt = 3'b000;
        end
      endcase
      case (w_gnt)
        3'b001:  w_ptr_nxt = PTR_MEM;
        3'b010:  w_ptr_nxt = PTR_MD;
        3'b100:  w_ptr_nxt = PTR_ALU;
        default: w_ptr_nxt = r_ptr;
      endcase
    end
  end
`else
  // Fixed priority MEM > MD > ALU.
  always_comb begin
    w_gnt = 3'b000;
    if (RESET || Hold) begin
      w_gnt = 3'b000;
    end else if (w_valid[1]) begin
      w_gnt = 3'b010;
    end else if (w_valid[2]) begin
      w_gnt = 3'b100;
    end else if (w_valid[0]) begin
      w_gnt = 3'b001;
    end else begin
      w_gnt = 3'b000;
    end
  end
`endif

  // Route the winner's register index and data toward the output register.
  always_comb begin
    w_sel_reg  = AluReg;
    w_sel_data = AluData;
    case (w_gnt)
      3'b010: begin
        w_sel_reg  = MemReg;
        w_sel_data = MemData;
      end
      3'b100: begin
        w_sel_reg  = MdReg;
        w_sel_data = MdData;
      end
      default: begin
        w_sel_reg  = AluReg;
        w_sel_data = AluData;
      end
    endcase
  end

  assign w_any_gnt = |w_gnt;
  assign w_drop    = (DROP_R0 != 0) && (w_sel_reg == {ADDR_W{1'b0}});

  // Register-0 writes are still acknowledged; only the write enable is suppressed.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_write    <= 1'b0;
      r_reg      <= {ADDR_W{1'b0}};
      r_data     <= {DATA_W{1'b0}};
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= ~Hold & w_multi;
      if (w_any_gnt) begin
        r_write <= ~w_drop;
        r_reg   <= w_sel_reg;
        r_data  <= w_sel_data;
      end else begin
        r_write <= 1'b0;
      end
    end
  end

  assign AluReady   = w_gnt[0];
  assign MemReady   = w_gnt[1];
  assign MdReady    = w_gnt[2];
  assign Write1     = r_write;
  assign WriteReg1  = r_reg;
  assign WriteData1 = r_data;
  assign Conflict   = r_conflict;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter; expectations follow WBARB_ROUND_ROBIN_EN.
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Hold;
  logic        AluValid, MemValid, MdValid;
  logic [4:0]  AluReg, MemReg, MdReg;
  logic [31:0] AluData, MemData, MdData;
  logic        AluReady, MemReady, MdReady;
  logic        Write1;
  logic [4:0]  WriteReg1;
  logic [31:0] WriteData1;
  logic        Conflict;

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DROP_R0(1)) dut (
    .CLK(CLK), .RESET(RESET), .Hold(Hold),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData), .MemReady(MemReady),
    .MdValid(MdValid), .MdReg(MdReg), .MdData(MdData), .MdReady(MdReady),
    .Write1(Write1), .WriteReg1(WriteReg1), .WriteData1(WriteData1), .Conflict(Conflict)
  );

  always #5 CLK = ~CLK;

`ifdef WBARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [31:0] DA = 32'hA1A1_0001;
  localparam logic [31:0] DB = 32'hB2B2_0002;
  localparam logic [31:0] DC = 32'hC3C3_0003;

  typedef struct {
    string       nm;
    bit          hold;
    bit [2:0]    v;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic [4:0]  mr;
    logic [31:0] md;
    logic [4:0]  dr;
    logic [31:0] dd;
    bit [2:0]    rdy;
    bit          w;
    logic [4:0]  wr;
    logic [31:0] wd;
    bit          conf;
  } vec_t;

  vec_t        tbl[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] shadow [0:31];

  // Register-file model: commits whatever the write port presents at each edge.
  always @(posedge CLK) begin
    if (Write1) shadow[WriteReg1] <= WriteData1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input bit h, input bit [2:0] v,
                              input logic [4:0] ar, input logic [31:0] ad,
                              input logic [4:0] mr, input logic [31:0] md,
                              input logic [4:0] dr, input logic [31:0] dd,
                              input bit [2:0] rdy, input bit w, input logic [4:0] wr,
                              input logic [31:0] wd, input bit conf);
    vec_t e;
    e.nm = nm; e.hold = h; e.v = v;
    e.ar = ar; e.ad = ad; e.mr = mr; e.md = md; e.dr = dr; e.dd = dd;
    e.rdy = rdy; e.w = w; e.wr = wr; e.wd = wd; e.conf = conf;
    tbl.push_back(e);
  endfunction

  task automatic drive(input vec_t e);
    Hold     = e.hold;
    AluValid = e.v[0]; AluReg = e.ar; AluData = e.ad;
    MemValid = e.v[1]; MemReg = e.mr; MemData = e.md;
    MdValid  = e.v[2]; MdReg  = e.dr; MdData  = e.dd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Contention: each requester drops Valid once granted.
    add("cont1", 1'b0, 3'b111, 5'd1, DA, 5'd2, DB, 5'd3, DC,
        RR ? 3'b001 : 3'b010, 1'b1, RR ? 5'd1 : 5'd2, RR ? DA : DB, 1'b1);
    add("cont2", 1'b0, RR ? 3'b110 : 3'b101, 5'd1, DA, 5'd2, DB, 5'd3, DC,
        RR ? 3'b010 : 3'b100, 1'b1, RR ? 5'd2 : 5'd3, RR ? DB : DC, 1'b1);
    add("cont3", 1'b0, RR ? 3'b100 : 3'b001, 5'd1, DA, 5'd2, DB, 5'd3, DC,
        RR ? 3'b100 : 3'b001, 1'b1, RR ? 5'd3 : 5'd1, RR ? DC : DA, 1'b0);
    add("idle", 1'b0, 3'b000, 5'd1, DA, 5'd2, DB, 5'd3, DC,
        3'b000, 1'b0, RR ? 5'd3 : 5'd1, RR ? DC : DA, 1'b0);
    add("single", 1'b0, 3'b001, 5'd5, 32'hDEADBEEF, 5'd2, DB, 5'd3, DC,
        3'b001, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    add("idle2", 1'b0, 3'b000, 5'd1, DA, 5'd2, DB, 5'd3, DC,
        3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      add("hold", 1'b1, 3'b111, 5'd1, DA, 5'd2, DB, 5'd3, DC,
          3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0);
    end
    add("resume1", 1'b0, 3'b111, 5'd1, DA, 5'd2, DB, 5'd3, DC, 3'b010, 1'b1, 5'd2, DB, 1'b1);
    add("resume2", 1'b0, 3'b101, 5'd1, DA, 5'd2, DB, 5'd3, DC, 3'b100, 1'b1, 5'd3, DC, 1'b1);
    add("resume3", 1'b0, 3'b001, 5'd1, DA, 5'd2, DB, 5'd3, DC, 3'b001, 1'b1, 5'd1, DA, 1'b0);
    add("reg0", 1'b0, 3'b010, 5'd1, DA, 5'd0, 32'h1234, 5'd3, DC,
        3'b010, 1'b0, 5'd0, 32'h1234, 1'b0);
    add("md9", 1'b0, 3'b100, 5'd1, DA, 5'd2, DB, 5'd9, 32'h99, 3'b100, 1'b1, 5'd9, 32'h99, 1'b0);
    add("same1", 1'b0, 3'b101, 5'd7, 32'h11, 5'd2, DB, 5'd7, 32'h22,
        RR ? 3'b001 : 3'b100, 1'b1, 5'd7, RR ? 32'h11 : 32'h22, 1'b1);
    add("same2", 1'b0, RR ? 3'b100 : 3'b001, 5'd7, 32'h11, 5'd2, DB, 5'd7, 32'h22,
        RR ? 3'b100 : 3'b001, 1'b1, 5'd7, RR ? 32'h22 : 32'h11, 1'b0);
    add("idle3", 1'b0, 3'b000, 5'd7, 32'h11, 5'd2, DB, 5'd7, 32'h22,
        3'b000, 1'b0, 5'd7, RR ? 32'h22 : 32'h11, 1'b0);

    RESET = 1'b1; Hold = 1'b0;
    AluValid = 1'b1; AluReg = 5'd1; AluData = DA;
    MemValid = 1'b1; MemReg = 5'd2; MemData = DB;
    MdValid  = 1'b1; MdReg  = 5'd3; MdData  = DC;
    @(posedge CLK); #1;
    chk("rst_ready", {29'd0, MdReady, MemReady, AluReady}, 32'd0);
    chk("rst_write1", {31'd0, Write1}, 32'd0);
    chk("rst_wreg", {27'd0, WriteReg1}, 32'd0);
    chk("rst_wdata", WriteData1, 32'd0);
    chk("rst_conflict", {31'd0, Conflict}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge CLK);
      RESET = 1'b0;
      drive(tbl[i]);
      #1;
      chk({tbl[i].nm, "_ready"}, {29'd0, MdReady, MemReady, AluReady}, {29'd0, tbl[i].rdy});
      @(posedge CLK); #1;
      chk({tbl[i].nm, "_write1"}, {31'd0, Write1}, {31'd0, tbl[i].w});
      chk({tbl[i].nm, "_wreg"}, {27'd0, WriteReg1}, {27'd0, tbl[i].wr});
      chk({tbl[i].nm, "_wdata"}, WriteData1, tbl[i].wd);
      chk({tbl[i].nm, "_conflict"}, {31'd0, Conflict}, {31'd0, tbl[i].conf});
    end
    chk("same_dest_final", shadow[7], RR ? 32'h22 : 32'h11);

    // Reset in the middle of traffic.
    @(negedge CLK);
    AluValid = 1'b1; AluReg = 5'd4; AluData = 32'h44;
    MemValid = 1'b0; MemReg = 5'd2; MemData = DB;
    MdValid  = 1'b0; MdReg  = 5'd3; MdData  = DC;
    #1;
    chk("mid_ready", {29'd0, MdReady, MemReady, AluReady}, 32'd1);
    @(posedge CLK); #1;
    chk("mid_write1", {31'd0, Write1}, 32'd1);
    chk("mid_wdata", WriteData1, 32'h44);
    @(negedge CLK);
    AluReg = 5'd6; AluData = 32'h66;
    RESET = 1'b1;
    #1;
    chk("async_ready", {29'd0, MdReady, MemReady, AluReady}, 32'd0);
    chk("async_write1", {31'd0, Write1}, 32'd0);
    chk("async_wreg", {27'd0, WriteReg1}, 32'd0);
    chk("async_wdata", WriteData1, 32'd0);
    @(posedge CLK); #1;
    chk("inrst_write1", {31'd0, Write1}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    MemValid = 1'b1; MdValid = 1'b1;
    #1;
    chk("post_rst_ready", {29'd0, MdReady, MemReady, AluReady}, RR ? 32'd1 : 32'd2);
    @(posedge CLK); #1;
    chk("post_rst_write1", {31'd0, Write1}, 32'd1);
    chk("post_rst_wdata", WriteData1, RR ? 32'h66 : DB);
    chk("post_rst_conflict", {31'd0, Conflict}, 32'd1);
    @(negedge CLK);
    AluValid = 1'b0; MemValid = 1'b0; MdValid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
